// File: rtl/intr_ctrl.sv
// intr_ctrl: 7 device lines plus a compare timer, with pending/enable/mode registers, claim and in-service capture
module intr_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [6:0]  Dev_irq,
  input  logic [3:0]  Bus_addr,
  input  logic [31:0] Bus_wdata,
  input  logic        Bus_w_en,
  input  logic        Bus_r_en,
  output logic [31:0] Bus_rdata,
  input  logic        Cp0_intr,
  output logic [7:0]  Interrupt
);
  logic [6:0]  sync1, sync2, prev, mode;
  logic [7:0]  pend, en, pe, w1c, pend_nx;
  logic [31:0] tcnt, tcmp, claim, rd;
  logic [1:0]  tctrl;
  logic [3:0]  insvc;
  logic [2:0]  idx;
  logic        match;
  always_comb begin
    pe = pend & en;
    match = tctrl[0] && tcnt == tcmp;
    w1c = (Bus_w_en && Bus_addr == 4'd0) ? Bus_wdata[7:0] : 8'd0;
    // a fresh edge or timer match beats a W1C landing in the same cycle
    pend_nx = {match | (pend[7] & ~w1c[7]),
               (mode & ((sync2 & ~prev) | (pend[6:0] & ~w1c[6:0]))) | (~mode & sync2)};
    idx = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (pe[i]) idx = 3'(i);
    claim = {|pe, 28'd0, idx};
    case (Bus_addr)
      4'd0:    rd = {24'd0, pend};
      4'd1:    rd = {24'd0, en};
      4'd2:    rd = {25'd0, mode};
      4'd3:    rd = tcnt;
      4'd4:    rd = tcmp;
      4'd5:    rd = {30'd0, tctrl};
      4'd6:    rd = claim;
      4'd7:    rd = {28'd0, insvc};
      default: rd = 32'd0;
    endcase
  end
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1 <= '0;
      sync2 <= '0;
      prev <= '0;
      pend <= '0;
      en <= '0;
      mode <= '0;
      tcnt <= '0;
      tcmp <= '1;
      tctrl <= '0;
      insvc <= '0;
      Interrupt <= '0;
      Bus_rdata <= '0;
    end else begin
      sync1 <= Dev_irq;
      sync2 <= sync1;
      prev <= sync2;
      pend <= pend_nx;
      Interrupt <= pe;
      if (Cp0_intr) insvc <= {claim[31], claim[2:0]};
      if (Bus_r_en) Bus_rdata <= rd;
      if (Bus_w_en && Bus_addr == 4'd3) tcnt <= Bus_wdata;
      else if (tctrl[0]) tcnt <= (match && tctrl[1]) ? 32'd0 : tcnt + 32'd1;
      if (Bus_w_en) begin
        if (Bus_addr == 4'd1) en <= Bus_wdata[7:0];
        if (Bus_addr == 4'd2) mode <= Bus_wdata[6:0];
        if (Bus_addr == 4'd4) tcmp <= Bus_wdata;
        if (Bus_addr == 4'd5) tctrl <= Bus_wdata[1:0];
      end
    end
  end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed and random stimulus against a sample-history reference model with a read scoreboard
module tb_intr_ctrl;
  logic        Clk = 0, Rst = 0, Bus_w_en = 0, Bus_r_en = 0, Cp0_intr = 0;
  logic [6:0]  Dev_irq = 0;
  logic [3:0]  Bus_addr = 0;
  logic [31:0] Bus_wdata = 0, Bus_rdata;
  logic [7:0]  Interrupt;
  int checks = 0, errors = 0;

  intr_ctrl dut (.Clk(Clk), .Rst(Rst), .Dev_irq(Dev_irq), .Bus_addr(Bus_addr), .Bus_wdata(Bus_wdata),
                 .Bus_w_en(Bus_w_en), .Bus_r_en(Bus_r_en), .Bus_rdata(Bus_rdata), .Cp0_intr(Cp0_intr),
                 .Interrupt(Interrupt));

  always #5 Clk = ~Clk;

  // s1/s2/s3: Dev_irq as sampled 1/2/3 edges ago
  logic [6:0]  s1, s2, s3, m_mode;
  logic [7:0]  m_pend, m_en, m_intr;
  logic [31:0] m_tcnt, m_tcmp;
  logic [1:0]  m_tctrl;
  logic [3:0]  m_insvc;
  logic        m_vld;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_claim();
    for (int i = 0; i < 8; i++)
      if (m_pend[i] && m_en[i]) return {1'b1, 28'd0, 3'(i)};
    return 32'd0;
  endfunction

  always @(posedge Clk or posedge Rst) begin : model
    logic [7:0]  np, w1c;
    logic        mt;
    logic [31:0] cl, rv;
    if (Rst) begin
      s1 = 0; s2 = 0; s3 = 0; m_pend = 0; m_en = 0; m_mode = 0; m_tcnt = 0;
      m_tcmp = 32'hFFFF_FFFF; m_tctrl = 0; m_insvc = 0; m_intr = 0; m_vld = 0;
      exp_q.delete();
    end else begin
      cl = m_claim();
      m_vld = Bus_r_en;
      if (Bus_r_en) begin
        case (Bus_addr)
          4'd0: rv = 32'(m_pend);
          4'd1: rv = 32'(m_en);
          4'd2: rv = 32'(m_mode);
          4'd3: rv = m_tcnt;
          4'd4: rv = m_tcmp;
          4'd5: rv = 32'(m_tctrl);
          4'd6: rv = cl;
          4'd7: rv = 32'(m_insvc);
          default: rv = 32'd0;
        endcase
        exp_q.push_back(rv);
      end
      mt = m_tctrl[0] && (m_tcnt == m_tcmp);
      w1c = (Bus_w_en && Bus_addr == 4'd0) ? Bus_wdata[7:0] : 8'd0;
      for (int i = 0; i < 7; i++)
        np[i] = !m_mode[i] ? s2[i] : ((s2[i] && !s3[i]) || (m_pend[i] && !w1c[i]));
      np[7] = mt || (m_pend[7] && !w1c[7]);
      if (Cp0_intr) m_insvc = {cl[31], cl[2:0]};
      m_intr = m_pend & m_en;
      m_pend = np;
      if (Bus_w_en && Bus_addr == 4'd3) m_tcnt = Bus_wdata;
      else if (m_tctrl[0]) m_tcnt = (mt && m_tctrl[1]) ? 32'd0 : m_tcnt + 32'd1;
      if (Bus_w_en)
        case (Bus_addr)
          4'd1: m_en = Bus_wdata[7:0];
          4'd2: m_mode = Bus_wdata[6:0];
          4'd4: m_tcmp = Bus_wdata;
          4'd5: m_tctrl = Bus_wdata[1:0];
          default: ;
        endcase
      s3 = s2; s2 = s1; s1 = Dev_irq;
    end
  end

  always @(negedge Clk) begin : monitor
    chk("interrupt", 32'(Interrupt), 32'(m_intr));
    if (m_vld) begin
      if (exp_q.size() == 0) chk("read_q_underflow", 32'd1, 32'd0);
      else chk("rdata", Bus_rdata, exp_q.pop_front());
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    Bus_w_en = 1; Bus_addr = a; Bus_wdata = d;
    @(negedge Clk);
    Bus_w_en = 0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] e, input string name);
    Bus_r_en = 1; Bus_addr = a;
    @(negedge Clk);
    Bus_r_en = 0;
    chk(name, Bus_rdata, e);
  endtask

  initial begin
    #1 Rst = 1;
    #1 chk("rst_intr", 32'(Interrupt), 0);
    chk("rst_rdata", Bus_rdata, 0);
    idle(3);
    Rst = 0;
    rd_chk(4, 32'hFFFF_FFFF, "tcmp_rst");
    rd_chk(0, 0, "pend_rst");
    rd_chk(3, 0, "tcnt_rst");
    // edge line 0: pending three edges after sampling, interrupt one more, W1C drops it two edges later
    wr(1, 1); wr(2, 1);
    Dev_irq[0] = 1;
    idle(2);
    rd_chk(0, 0, "pend_early");
    rd_chk(0, 1, "pend_edge");
    chk("intr_edge", 32'(Interrupt), 1);
    Dev_irq[0] = 0;
    wr(0, 1);
    chk("intr_w1c_hold", 32'(Interrupt), 1);
    idle(1);
    chk("intr_w1c_drop", 32'(Interrupt), 0);
    // level line 2 ignores W1C and follows the input
    wr(2, 0); wr(1, 4);
    Dev_irq[2] = 1;
    idle(4);
    rd_chk(0, 4, "lvl_pend");
    wr(0, 4);
    rd_chk(0, 4, "lvl_w1c");
    chk("lvl_intr", 32'(Interrupt), 4);
    Dev_irq[2] = 0;
    idle(3);
    chk("lvl_drop_hold", 32'(Interrupt), 4);
    idle(1);
    chk("lvl_drop", 32'(Interrupt), 0);
    // claim and in-service capture with PEND=0x28
    wr(2, 32'h7F); wr(1, 32'hFF);
    Dev_irq = 7'h28;
    idle(4);
    Dev_irq = 0;
    rd_chk(6, 32'h8000_0003, "claim");
    Cp0_intr = 1;
    idle(1);
    Cp0_intr = 0;
    rd_chk(7, 32'hB, "insvc");
    wr(1, 0);
    rd_chk(6, 0, "claim_none");
    wr(0, 32'hFF);
    // edge set and W1C of line 1 in the same cycle
    Dev_irq[1] = 1;
    idle(2);
    wr(0, 2);
    rd_chk(0, 2, "set_wins_1");
    Dev_irq[1] = 0;
    wr(0, 2);
    // timer match and W1C of bit 7 in the same cycle
    wr(4, 10); wr(3, 10); wr(5, 1); wr(0, 32'h80); wr(5, 0);
    rd_chk(0, 32'h80, "set_wins_7");
    wr(0, 32'h80);
    rd_chk(0, 0, "pend_clr");
    // auto-reload timer with period 6
    wr(3, 0); wr(4, 5); wr(1, 32'h80); wr(5, 3);
    idle(4);
    rd_chk(3, 4, "tcnt_run");
    rd_chk(0, 0, "tmr_pre");
    rd_chk(3, 0, "tcnt_reload");
    chk("tmr_intr", 32'(Interrupt), 32'h80);
    wr(0, 32'h80);
    idle(3);
    rd_chk(0, 0, "tmr_period_pre");
    rd_chk(0, 32'h80, "tmr_period");
    // asynchronous reset mid-run with everything pending
    wr(1, 32'hFF); wr(3, 100);
    Dev_irq = 7'h7F;
    idle(4);
    #2 Rst = 1;
    #1 chk("async_rst_intr", 32'(Interrupt), 0);
    chk("async_rst_rdata", Bus_rdata, 0);
    idle(2);
    Rst = 0;
    rd_chk(4, 32'hFFFF_FFFF, "tcmp_rst2");
    rd_chk(3, 0, "tcnt_rst2");
    rd_chk(1, 0, "en_rst2");
    rd_chk(0, 32'h7F, "pend_after_rst");
    chk("no_intr_after_rst", 32'(Interrupt), 0);
    Dev_irq = 0;
    // random traffic, checked by the model through the scoreboard and the interrupt monitor
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) Dev_irq = 7'($urandom);
      Bus_addr = 4'($urandom);
      Bus_w_en = $urandom_range(0, 3) == 0;
      Bus_r_en = $urandom_range(0, 1) == 1;
      Cp0_intr = $urandom_range(0, 7) == 0;
      Bus_wdata = (Bus_addr == 4'd3 || Bus_addr == 4'd4) ? $urandom_range(0, 40) : $urandom;
      @(negedge Clk);
    end
    Bus_w_en = 0; Bus_r_en = 0; Cp0_intr = 0;
    idle(3);
    chk("read_q_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
